// File: rtl/mul32p_issue.sv
// Issue/collect stage around the fixed-latency pipelined multiplier mul32p: credit-limited
// request issue, tag tracking and a result FIFO. Optional macro MUL32P_ISSUE_BYPASS_EN.
module mul32p_issue #(
  parameter int LAT   = 8,
  parameter int DEPTH = 8,
  parameter int TW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
  input  logic          in_mode,
  input  logic [TW-1:0] in_tag,
  output logic [31:0]   mul_a,
  output logic [31:0]   mul_b,
  output logic          mul_mode,
  input  logic [31:0]   mul_lo,
  input  logic [31:0]   mul_hi,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_lo,
  output logic [31:0]   out_hi,
  output logic          out_mode,
  output logic [TW-1:0] out_tag
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic          valid;
    logic          mode;
    logic [TW-1:0] tag;
  } trk_t;

  typedef struct packed {
    logic [31:0]   hi;
    logic [31:0]   lo;
    logic          mode;
    logic [TW-1:0] tag;
  } ent_t;

  logic [CW-1:0] cnt;
  trk_t          trk [LAT+1];
  ent_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic          accept;
  logic          pop;
  logic          fifo_wr;
  logic          fifo_rd;
  logic          fifo_empty;
  ent_t          cap;
  ent_t          head;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits cover everything in flight plus everything queued, so the FIFO can never overflow.
  assign in_ready   = !rst && (cnt < CW'(DEPTH));
  assign accept     = in_valid && in_ready;
  assign fifo_empty = (fifo_cnt == '0);
  assign cap        = {mul_hi, mul_lo, trk[LAT].mode, trk[LAT].tag};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    head      = '0;
    out_valid = 1'b0;
    if (!fifo_empty) begin
      head      = mem[rd_ptr];
      out_valid = 1'b1;
    end
`ifdef MUL32P_ISSUE_BYPASS_EN
    if (fifo_empty && trk[LAT].valid) begin
      head      = cap;
      out_valid = 1'b1;
    end
`endif
  end

  assign pop     = out_valid && out_ready;
  assign fifo_rd = pop && !fifo_empty;
`ifdef MUL32P_ISSUE_BYPASS_EN
  assign fifo_wr = trk[LAT].valid && !(fifo_empty && pop);
`else
  assign fifo_wr = trk[LAT].valid;
`endif

  assign out_hi   = head.hi;
  assign out_lo   = head.lo;
  assign out_mode = head.mode;
  assign out_tag  = head.tag;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_mode <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i <= LAT; i++) trk[i] <= '0;
    end else begin
      if (accept && !pop)      cnt <= cnt + 1'b1;
      else if (!accept && pop) cnt <= cnt - 1'b1;

      if (accept) begin
        mul_a    <= in_a;
        mul_b    <= in_b;
        mul_mode <= in_mode;
      end

      trk[0] <= '{valid: accept, mode: in_mode, tag: in_tag};
      for (int i = 1; i <= LAT; i++) trk[i] <= trk[i-1];

      if (fifo_wr) wr_ptr <= next_ptr(wr_ptr);
      if (fifo_rd) rd_ptr <= next_ptr(rd_ptr);
      if (fifo_wr && !fifo_rd)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!fifo_wr && fifo_rd) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  // NOTE: storage is not reset; the occupancy count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= cap;
  end
endmodule

// File: tb/tb_mul32p_issue.sv
// Self-checking bench for mul32p_issue: behavioural mul32p model, queue scoreboard,
// credit/overflow/hold monitors and directed plus randomized scenarios.
module tb_mul32p_issue;
  localparam int LAT   = 8;
  localparam int DEPTH = 8;
  localparam int TW    = 4;
`ifdef MUL32P_ISSUE_BYPASS_EN
  localparam int MIN_LAT = LAT + 1;
`else
  localparam int MIN_LAT = LAT + 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_a;
  logic [31:0]   in_b;
  logic          in_mode;
  logic [TW-1:0] in_tag;
  logic [31:0]   mul_a;
  logic [31:0]   mul_b;
  logic          mul_mode;
  logic [31:0]   mul_lo;
  logic [31:0]   mul_hi;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_lo;
  logic [31:0]   out_hi;
  logic          out_mode;
  logic [TW-1:0] out_tag;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mul32p_issue #(.LAT(LAT), .DEPTH(DEPTH), .TW(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .in_tag(in_tag),
    .mul_a(mul_a), .mul_b(mul_b), .mul_mode(mul_mode), .mul_lo(mul_lo), .mul_hi(mul_hi),
    .out_valid(out_valid), .out_ready(out_ready), .out_lo(out_lo), .out_hi(out_hi),
    .out_mode(out_mode), .out_tag(out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic m);
    longint sa, sb;
    if (m) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Free-running multiplier: operands present in cycle t give the product in cycle t+LAT.
  logic [63:0] mpipe [LAT];
  initial for (int i = 0; i < LAT; i++) mpipe[i] = '0;
  always @(posedge clk) begin
    mpipe[0] <= ref_prod(mul_a, mul_b, mul_mode);
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_lo = mpipe[LAT-1][31:0];
  assign mul_hi = mpipe[LAT-1][63:32];

  // Scoreboard: every accepted request must come back once, in order, with its own product.
  typedef struct {
    logic [63:0]   p;
    logic          mode;
    logic [TW-1:0] tag;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic        hold_v = 1'b0;
  logic [97:0] hold_val;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got tag=%0d lo=%h hi=%h with nothing outstanding",
                   out_tag, out_lo, out_hi);
        end else begin
          e = exp_q.pop_front();
          if ({out_hi, out_lo} !== e.p || out_mode !== e.mode || out_tag !== e.tag) begin
            bad++;
            $display("FAIL sb_result: got %h mode=%0d tag=%0d, want %h mode=%0d tag=%0d",
                     {out_hi, out_lo}, out_mode, out_tag, e.p, e.mode, e.tag);
          end
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back('{p: ref_prod(in_a, in_b, in_mode), mode: in_mode, tag: in_tag});
      if (hold_v) begin
        total++;
        if (!out_valid || {out_hi, out_lo, out_mode, out_tag} !== hold_val) begin
          bad++;
          $display("FAIL hold_stable: got valid=%0d %h, want valid=1 %h",
                   out_valid, {out_hi, out_lo, out_mode, out_tag}, hold_val);
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_val = {out_hi, out_lo, out_mode, out_tag};
      total++;
      if (int'(dut.cnt) > DEPTH) begin
        bad++;
        $display("FAIL credit_bound: cnt=%0d, want <= %0d", dut.cnt, DEPTH);
      end
      if (dut.fifo_wr) begin
        total++;
        if (int'(dut.fifo_cnt) == DEPTH) begin
          bad++;
          $display("FAIL fifo_overflow: write with occupancy=%0d, want < %0d", dut.fifo_cnt, DEPTH);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output int pops);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) pops++;
      tick();
    end
    total++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain: outstanding=%0d out_valid=%0d, want 0 and 0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_mode = 1'b0; in_tag = '0;
    repeat (3) tick();
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_in_ready_held: got %0d want 0", in_ready);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready_after: got %0d want 1", in_ready);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid: got %0d want 0", out_valid);
    end
    total++;
    if ({mul_a, mul_b, mul_mode} !== 65'd0) begin
      bad++; $display("FAIL reset_mul: got a=%h b=%h m=%0d want all 0", mul_a, mul_b, mul_mode);
    end
    total++;
    if ({out_lo, out_hi, out_mode, out_tag} !== '0) begin
      bad++;
      $display("FAIL reset_out: got lo=%h hi=%h m=%0d tag=%0d want all 0",
               out_lo, out_hi, out_mode, out_tag);
    end
  endtask

  task automatic test_single();
    int c0;
    bit found;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'd292; in_b = 32'd6785; in_mode = 1'b0; in_tag = 4'd3;
    c0 = cyc;
    tick();
    in_valid = 1'b0;
    total++;
    if (mul_a !== 32'd292 || mul_b !== 32'd6785 || mul_mode !== 1'b0) begin
      bad++; $display("FAIL single_mul_ops: got a=%0d b=%0d m=%0d want 292 6785 0",
                      mul_a, mul_b, mul_mode);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_valid) found = 1'b1;
      else tick();
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL single_timeout: no out_valid within 20 cycles");
    end else begin
      total++;
      if (cyc - c0 != MIN_LAT) begin
        bad++; $display("FAIL single_latency: got %0d want %0d", cyc - c0, MIN_LAT);
      end
      total++;
      if ({out_hi, out_lo} !== 64'd292 * 64'd6785 || out_tag !== 4'd3 || out_mode !== 1'b0) begin
        bad++; $display("FAIL single_result: got hi=%h lo=%h tag=%0d m=%0d want %h tag=3 m=0",
                        out_hi, out_lo, out_tag, out_mode, 64'd292 * 64'd6785);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] got_p [2];
    int          got_c [2];
    int          n;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_mode = 1'b0; in_tag = 4'd5;
    tick();
    in_mode = 1'b1; in_tag = 4'd6;
    tick();
    in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid && out_ready && n < 2) begin
        got_p[n] = {out_hi, out_lo};
        got_c[n] = cyc;
        n++;
      end
      tick();
    end
    total++;
    if (n != 2) begin
      bad++; $display("FAIL b2b_count: got %0d results want 2", n);
    end else begin
      total++;
      if (got_p[0] !== 64'hFFFF_FFFE_0000_0001) begin
        bad++; $display("FAIL b2b_unsigned: got %h want fffffffe00000001", got_p[0]);
      end
      total++;
      if (got_p[1] !== 64'h0000_0000_0000_0001) begin
        bad++; $display("FAIL b2b_signed: got %h want 0000000000000001", got_p[1]);
      end
      total++;
      if (got_c[1] - got_c[0] != 1) begin
        bad++; $display("FAIL b2b_spacing: got %0d cycles want 1", got_c[1] - got_c[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int n;
    logic [TW-1:0] tags [DEPTH];
    bit hs;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      in_a = $urandom; in_b = $urandom; in_mode = 1'($urandom); in_tag = TW'(acc);
      hs = in_ready;
      tick();
      if (hs) acc++;
    end
    in_valid = 1'b0;
    total++;
    if (acc != DEPTH || in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_accept: got %0d accepted in_ready=%0d want %0d and 0",
                      acc, in_ready, DEPTH);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_first_pop: got in_ready=%0d out_valid=%0d want 0 1",
                      in_ready, out_valid);
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid && n < DEPTH) begin
        tags[n] = out_tag;
        n++;
      end
      tick();
      if (i == 0) begin
        total++;
        if (in_ready !== 1'b1) begin
          bad++; $display("FAIL bp_credit_return: got in_ready=%0d want 1", in_ready);
        end
      end
    end
    total++;
    if (n != DEPTH) begin
      bad++; $display("FAIL bp_pop_count: got %0d want %0d", n, DEPTH);
    end
    for (int i = 0; i < n; i++) begin
      total++;
      if (tags[i] !== TW'(i)) begin
        bad++; $display("FAIL bp_order: slot %0d got tag %0d want %0d", i, tags[i], i);
      end
    end
  endtask

  task automatic test_stream();
    int acc;
    int pops;
    int extra;
    bit hs;
    in_valid = 1'b1; in_a = 32'h8FA4_B672; in_b = 32'h6C3F_8132; in_mode = 1'b1;
    acc = 0; pops = 0;
    for (int i = 0; i < 150; i++) begin
      in_tag    = TW'(acc);
      out_ready = 1'($urandom_range(0, 1));
      hs = in_ready;
      if (out_valid && out_ready) begin
        pops++;
        total++;
        if ({out_hi, out_lo} !== ref_prod(32'h8FA4_B672, 32'h6C3F_8132, 1'b1)) begin
          bad++; $display("FAIL stream_value: got %h want %h", {out_hi, out_lo},
                          ref_prod(32'h8FA4_B672, 32'h6C3F_8132, 1'b1));
        end
      end
      tick();
      if (hs) acc++;
    end
    drain(extra);
    total++;
    if (pops + extra != acc) begin
      bad++; $display("FAIL stream_count: got %0d results want %0d", pops + extra, acc);
    end
  endtask

  task automatic test_random();
    int pops;
    bit hs;
    int acc;
    acc = 0;
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom);
      in_a      = $urandom;
      in_b      = $urandom;
      in_mode   = 1'($urandom);
      in_tag    = TW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      hs = in_valid && in_ready;
      tick();
      if (hs) acc++;
    end
    drain(pops);
    total++;
    if (acc == 0) begin
      bad++; $display("FAIL random_accepts: got 0 accepted want > 0");
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit found;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_a = $urandom; in_b = $urandom; in_mode = 1'($urandom); in_tag = TW'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL rst_mid_flush: got out_valid=1 after reset want 0");
    end
    in_valid = 1'b1; in_a = 32'd2; in_b = 32'd3; in_mode = 1'b0; in_tag = 4'd9;
    tick();
    in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_valid) found = 1'b1;
      else tick();
    end
    total++;
    if (!found || {out_hi, out_lo} !== 64'd6 || out_tag !== 4'd9) begin
      bad++; $display("FAIL rst_mid_fresh: got valid=%0d %h tag=%0d want 1 6 tag=9",
                      found, {out_hi, out_lo}, out_tag);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_stream();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
